branch_predictor: RTL
=====================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: i_clk (rising edge) and i_rst_n.
REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- i_clk  in  1  clock
- i_rst_n  in  1  async active-low reset
- i_f_pc  in  32  fetch PC being looked up
- o_pred_taken  out  1  predict redirect for i_f_pc
- o_pred_target  out  32  predicted target (0 when o_pred_taken=0)
- i_r_valid  in  1  resolution from execute is valid this cycle
- i_r_pc  in  32  PC of resolved instruction
- i_r_branch  in  1  resolved instr is conditional branch
- i_r_jal  in  1  resolved instr is JAL
- i_r_taken  in  1  actual outcome (1 for JAL)
- i_r_target  in  32  actual taken target (PC+imm)
- i_r_pred_taken  in  1  prediction carried down pipe with instr
- i_r_pred_target  in  32  predicted target carried down pipe
- o_flush  out  1  mispredict, redirect fetch
- o_flush_pc  out  32  correct next PC
- o_br_cnt  out  16  resolved branch+JAL count
- o_mp_cnt  out  16  mispredict count

Function
REQ-003 Table: 16 entries; index = pc[5:2], tag = pc[31:6]; each entry holds valid, tag[25:0], target[31:0], jal bit, 2-bit saturating counter.
REQ-004 Lookup SHALL be combinational from registered table state: hit = valid & tag match at index i_f_pc[5:2].
REQ-005 o_pred_taken = hit & (jal | ctr[1]); o_pred_target = entry target when o_pred_taken, else 0.
REQ-006 Update SHALL occur at the clock edge when i_r_valid & (i_r_branch | i_r_jal); otherwise the table SHALL hold.
REQ-007 Update on hit: branch -> ctr +1 if taken (saturate 11), -1 if not taken (saturate 00); target written only if taken; jal bit rewritten.
REQ-008 Update on miss and taken: allocate/overwrite entry: valid=1, tag, target=i_r_target, jal=i_r_jal, ctr=10.
REQ-009 Update on miss and not taken: no table write.
REQ-010 Same-cycle lookup and update to the same index: lookup SHALL return pre-update state (no bypass).
REQ-011 Mispredict (evaluated only on valid update) = (i_r_pred_taken != i_r_taken) | (i_r_pred_taken & i_r_taken & i_r_pred_target != i_r_target).
REQ-012 o_flush SHALL be registered: asserted exactly one cycle after the resolving edge, for one cycle per mispredict; back-to-back mispredicts SHALL give back-to-back pulses.
REQ-013 o_flush_pc (registered with o_flush) = i_r_target if taken, else i_r_pc + 4 (32-bit wrap on overflow); holds last value when o_flush=0.
REQ-014 o_br_cnt SHALL increment on each valid update; o_mp_cnt on each mispredict; both saturate at 16'hFFFF.
REQ-015 Instructions with i_r_valid=0 or neither branch nor jal (e.g. JALR) SHALL not affect table, counters or o_flush.

Reset
REQ-016 i_rst_n low SHALL immediately (asynchronously) clear all valid bits, set all ctr to 01, tags/targets/jal to 0, o_flush=0, o_flush_pc=0, o_br_cnt=0, o_mp_cnt=0.
REQ-017 During and immediately after reset, every lookup SHALL miss (o_pred_taken=0, o_pred_target=0).
REQ-018 Reset asserted mid-operation SHALL discard any pending flush and updates; first update is accepted on the first rising edge with i_rst_n high.

Verification
REQ-019 Cold miss: after reset, i_f_pc=0x100 -> o_pred_taken=0, o_pred_target=0.
REQ-020 Allocate: resolve branch pc=0x100 taken target=0x140, pred_taken=0 -> next cycle o_flush=1, o_flush_pc=0x140, o_mp_cnt=1; then lookup 0x100 -> taken, 0x140.
REQ-021 Hysteresis: from ctr=10, one not-taken at 0x100 -> ctr=01, lookup not taken, o_flush_pc=0x104; two taken -> ctr=11; three further taken keep 11.
REQ-022 Alias: entry for 0x100 valid, lookup 0x500 (same index, different tag) -> miss; not-taken resolve of 0x500 leaves 0x100 entry intact.
REQ-023 JAL: resolve jal pc=0x200 target=0x80 -> later lookup 0x200 predicts taken, 0x80 regardless of ctr; correct prediction -> no o_flush, o_br_cnt increments.
REQ-024 Reset mid-op: mispredict resolved, i_rst_n dropped before next edge -> o_flush stays 0, all lookups miss, counters 0.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped 16-entry branch target buffer with 2-bit counters and a JAL bit.
// Resolutions from execute train the table; mispredicts raise a one-cycle flush.
module branch_predictor (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_f_pc,
  output logic        o_pred_taken,
  output logic [31:0] o_pred_target,
  input  logic        i_r_valid,
  input  logic [31:0] i_r_pc,
  input  logic        i_r_branch,
  input  logic        i_r_jal,
  input  logic        i_r_taken,
  input  logic [31:0] i_r_target,
  input  logic        i_r_pred_taken,
  input  logic [31:0] i_r_pred_target,
  output logic        o_flush,
  output logic [31:0] o_flush_pc,
  output logic [15:0] o_br_cnt,
  output logic [15:0] o_mp_cnt
);

  localparam int ENTRIES = 16;

  logic [ENTRIES-1:0] valid;
  logic [ENTRIES-1:0] jal;
  logic [25:0]        tag    [ENTRIES];
  logic [31:0]        target [ENTRIES];
  logic [1:0]         ctr    [ENTRIES];

  logic [3:0]  f_idx;
  logic        f_hit;
  logic [3:0]  r_idx;
  logic        r_hit;
  logic        upd;
  logic        mispredict;

  logic        flush_p1;
  logic [31:0] flush_pc_p1;
  logic [15:0] br_cnt;
  logic [15:0] mp_cnt;

  function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic taken);
    if (taken) ctr_step = (c == 2'b11) ? c : c + 2'd1;
    else       ctr_step = (c == 2'b00) ? c : c - 2'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Lookup reads registered state only, so a same-cycle update is not visible.
  assign f_idx         = i_f_pc[5:2];
  assign f_hit         = valid[f_idx] && (tag[f_idx] == i_f_pc[31:6]);
  assign o_pred_taken  = f_hit && (jal[f_idx] || ctr[f_idx][1]);
  assign o_pred_target = o_pred_taken ? target[f_idx] : 32'd0;

  assign r_idx      = i_r_pc[5:2];
  assign r_hit      = valid[r_idx] && (tag[r_idx] == i_r_pc[31:6]);
  assign upd        = i_r_valid && (i_r_branch || i_r_jal);
  assign mispredict = (i_r_pred_taken != i_r_taken) ||
                      (i_r_pred_taken && i_r_taken && (i_r_pred_target != i_r_target));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid <= '0;
      jal   <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag[i]    <= '0;
        target[i] <= '0;
        ctr[i]    <= 2'b01;
      end
    end else if (upd) begin
      if (r_hit) begin
        if (i_r_branch) ctr[r_idx] <= ctr_step(ctr[r_idx], i_r_taken);
        if (i_r_taken)  target[r_idx] <= i_r_target;
        jal[r_idx] <= i_r_jal;
      end else if (i_r_taken) begin
        valid[r_idx]  <= 1'b1;
        tag[r_idx]    <= i_r_pc[31:6];
        target[r_idx] <= i_r_target;
        jal[r_idx]    <= i_r_jal;
        ctr[r_idx]    <= 2'b10;
      end
    end
  end

  // Stage p1: registered flush and statistics
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      flush_p1    <= 1'b0;
      flush_pc_p1 <= '0;
      br_cnt      <= '0;
      mp_cnt      <= '0;
    end else begin
      flush_p1 <= upd && mispredict;
      if (upd && mispredict) flush_pc_p1 <= i_r_taken ? i_r_target : i_r_pc + 32'd4;
      if (upd) br_cnt <= sat_inc16(br_cnt);
      if (upd && mispredict) mp_cnt <= sat_inc16(mp_cnt);
    end
  end

  assign o_flush    = flush_p1;
  assign o_flush_pc = flush_pc_p1;
  assign o_br_cnt   = br_cnt;
  assign o_mp_cnt   = mp_cnt;

endmodule
